// File: rtl/vec_pkg.sv
// Shared types and constants for the vector issue sequencer and its register file.
package vec_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 32;
    localparam int VEC_W  = LANES * LANE_W;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } seq_state_t;

endpackage

// File: rtl/vec_regfile.sv
// Vector register file: NREG x VEC_W storage, three combinational read ports,
// write port A (shared with the host load path) and write port B.
// When A and B target the same entry in one cycle, B's data is kept.
module vec_regfile
    import vec_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    // write port A (ALU low word)
    input  logic             wa_en_i,
    input  logic [AW-1:0]    wa_addr_i,
    input  logic [VEC_W-1:0] wa_data_i,
    // write port B (ALU high word / carry), wins over port A
    input  logic             wb_en_i,
    input  logic [AW-1:0]    wb_addr_i,
    input  logic [VEC_W-1:0] wb_data_i,
    // host write, shares the port A write path
    input  logic             ld_en_i,
    input  logic [AW-1:0]    ld_addr_i,
    input  logic [VEC_W-1:0] ld_data_i,
    // combinational read ports
    input  logic [AW-1:0]    r1_addr_i,
    output logic [VEC_W-1:0] r1_data_o,
    input  logic [AW-1:0]    r2_addr_i,
    output logic [VEC_W-1:0] r2_data_o,
    input  logic [AW-1:0]    r3_addr_i,
    output logic [VEC_W-1:0] r3_data_o
);

    logic [VEC_W-1:0] mem_q [NREG];

    // Storage update: reset clears every entry; port B is written last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wa_en_i) begin
                mem_q[wa_addr_i] <= wa_data_i;
            end else if (ld_en_i) begin
                mem_q[ld_addr_i] <= ld_data_i;
            end
            if (wb_en_i) begin
                mem_q[wb_addr_i] <= wb_data_i;
            end
        end
    end

    assign r1_data_o = mem_q[r1_addr_i];
    assign r2_data_o = mem_q[r2_addr_i];
    assign r3_data_o = mem_q[r3_addr_i];

endmodule

// File: rtl/vec_alu_seq.sv
// Issue sequencer in front of the 16-lane ALU: accepts one instruction,
// presents two source vectors for one cycle, then writes both ALU result
// words back to the register file. Also exposes a host load/read port.
module vec_alu_seq
    import vec_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    // instruction handshake
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [AW-1:0]    in_src1,
    input  logic [AW-1:0]    in_src2,
    input  logic [AW-1:0]    in_dst_lo,
    input  logic [AW-1:0]    in_dst_hi,
    // host register port
    input  logic             ld_en,
    output logic             ld_ready,
    input  logic [AW-1:0]    ld_addr,
    input  logic [VEC_W-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [VEC_W-1:0] rd_data,
    // ALU interface
    output logic             alu_en,
    output logic             alu_op,
    output logic [VEC_W-1:0] alu_a1,
    output logic [VEC_W-1:0] alu_a2,
    input  logic [VEC_W-1:0] alu_a3,
    input  logic [VEC_W-1:0] alu_a4,
    // writeback strobe
    output logic             done
);

    seq_state_t       state_q, state_d;

    logic             op_q, op_d;
    logic [AW-1:0]    src1_q, src1_d;
    logic [AW-1:0]    src2_q, src2_d;
    logic [AW-1:0]    dst_lo_q, dst_lo_d;
    logic [AW-1:0]    dst_hi_q, dst_hi_d;

    logic             accept;
    logic             wb_we;
    logic             host_we;
    logic [VEC_W-1:0] src1_data;
    logic [VEC_W-1:0] src2_data;

    assign accept  = (state_q == IDLE) && in_valid;
    assign host_we = ld_en && ld_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a fixed IDLE -> ISSUE -> WB -> IDLE walk, entered on accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ISSUE;
            ISSUE:   state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Instruction latch next-state: capture the fields only on the accept edge.
    always_comb begin
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dst_lo_d = dst_lo_q;
        dst_hi_d = dst_hi_q;
        if (accept) begin
            op_d     = in_op;
            src1_d   = in_src1;
            src2_d   = in_src2;
            dst_lo_d = in_dst_lo;
            dst_hi_d = in_dst_hi;
        end
    end

    // Instruction latch: pure data, every use is gated by the FSM state.
    always_ff @(posedge clk) begin
        op_q     <= op_d;
        src1_q   <= src1_d;
        src2_q   <= src2_d;
        dst_lo_q <= dst_lo_d;
        dst_hi_q <= dst_hi_d;
    end

    // Outputs: ALU drive only in ISSUE, writeback and host stall only in WB.
    // A reset arriving during WB suppresses the done strobe for that cycle.
    always_comb begin
        in_ready = 1'b0;
        ld_ready = 1'b1;
        alu_en   = 1'b0;
        alu_op   = 1'b0;
        alu_a1   = '0;
        alu_a2   = '0;
        wb_we    = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            ISSUE: begin
                alu_en = 1'b1;
                alu_op = op_q;
                alu_a1 = src1_data;
                alu_a2 = src2_data;
            end
            WB: begin
                ld_ready = 1'b0;
                wb_we    = 1'b1;
                done     = !rst;
            end
            default: ;
        endcase
    end

    vec_regfile #(
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .wa_en_i   (wb_we),
        .wa_addr_i (dst_lo_q),
        .wa_data_i (alu_a3),
        .wb_en_i   (wb_we),
        .wb_addr_i (dst_hi_q),
        .wb_data_i (alu_a4),
        .ld_en_i   (host_we),
        .ld_addr_i (ld_addr),
        .ld_data_i (ld_data),
        .r1_addr_i (src1_q),
        .r1_data_o (src1_data),
        .r2_addr_i (src2_q),
        .r2_data_o (src2_data),
        .r3_addr_i (rd_addr),
        .r3_data_o (rd_data)
    );

endmodule

// File: tb/tb_vec_alu_seq.sv
// Bench for vec_alu_seq: a behavioural one-cycle-latency ALU, a shadow
// register file feeding a scoreboard queue, a vector table and corner sequences.
module tb_vec_alu_seq;
    import vec_pkg::*;

    localparam int NREG = 8;
    localparam int AW   = 3;

    typedef logic [VEC_W-1:0] vec_t;

    typedef struct {
        logic op;
        int   s1;
        int   s2;
        int   dl;
        int   dh;
        vec_t v1;
        vec_t v2;
        vec_t exp_lo;
        vec_t exp_hi;
    } tv_t;

    typedef struct {
        int   dl;
        int   dh;
        vec_t lo;
        vec_t hi;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_op;
    logic [AW-1:0] in_src1, in_src2, in_dst_lo, in_dst_hi;
    logic          ld_en;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    vec_t          ld_data;
    logic [AW-1:0] rd_addr;
    vec_t          rd_data;
    logic          alu_en;
    logic          alu_op;
    vec_t          alu_a1, alu_a2, alu_a3, alu_a4;
    logic          done;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t shadow [NREG];
    sb_t  sbq [$];
    tv_t  tv [5];

    always #5 clk = ~clk;

    vec_alu_seq #(.NREG(NREG), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .in_dst_lo (in_dst_lo),
        .in_dst_hi (in_dst_hi),
        .ld_en     (ld_en),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_a1    (alu_a1),
        .alu_a2    (alu_a2),
        .alu_a3    (alu_a3),
        .alu_a4    (alu_a4),
        .done      (done)
    );

    // Lane-wise ALU function: low or high 32 bits of the 64-bit sum/product.
    function automatic vec_t alu_fn(input logic op, input vec_t a, input vec_t b, input logic sel_hi);
        vec_t        r;
        logic [63:0] p;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            if (op) p = 64'(a[k*32 +: 32]) * 64'(b[k*32 +: 32]);
            else    p = 64'(a[k*32 +: 32]) + 64'(b[k*32 +: 32]);
            r[k*32 +: 32] = sel_hi ? p[63:32] : p[31:0];
        end
        return r;
    endfunction

    function automatic vec_t splat(input logic [31:0] w);
        return {LANES{w}};
    endfunction

    function automatic vec_t ramp(input logic [31:0] base, input logic [31:0] step);
        vec_t r;
        r = '0;
        for (int k = 0; k < LANES; k++) r[k*32 +: 32] = base + 32'(k) * step;
        return r;
    endfunction

    // External ALU model: results valid the cycle after alu_en, garbage otherwise.
    always @(posedge clk) begin
        if (alu_en) begin
            alu_a3 <= alu_fn(alu_op, alu_a1, alu_a2, 1'b0);
            alu_a4 <= alu_fn(alu_op, alu_a1, alu_a2, 1'b1);
        end else begin
            alu_a3 <= {LANES{$urandom()}};
            alu_a4 <= {LANES{$urandom()}};
        end
    end

    task automatic check(input string name, input vec_t act, input vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string name, input int a, input vec_t exp);
        rd_addr = AW'(a);
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic load(input int a, input vec_t d);
        ld_en   = 1'b1;
        ld_addr = AW'(a);
        ld_data = d;
        tick();
        ld_en   = 1'b0;
        shadow[a] = d;
    endtask

    task automatic set_instr(input logic op, input int s1, input int s2, input int dl, input int dh);
        in_op     = op;
        in_src1   = AW'(s1);
        in_src2   = AW'(s2);
        in_dst_lo = AW'(dl);
        in_dst_hi = AW'(dh);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    // Predict the writeback from the shadow file and queue it.
    task automatic sb_push(input logic op, input int s1, input int s2, input int dl, input int dh);
        vec_t lo, hi;
        sb_t  e;
        lo = alu_fn(op, shadow[s1], shadow[s2], 1'b0);
        hi = alu_fn(op, shadow[s1], shadow[s2], 1'b1);
        shadow[dl] = lo;
        shadow[dh] = hi;
        e.dl = dl;
        e.dh = dh;
        e.lo = shadow[dl];
        e.hi = shadow[dh];
        sbq.push_back(e);
    endtask

    task automatic sb_drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            rd_check("sb_dst_lo", e.dl, e.lo);
            rd_check("sb_dst_hi", e.dh, e.hi);
        end
    endtask

    task automatic issue(input logic op, input int s1, input int s2, input int dl, input int dh);
        vec_t va, vb;
        va = shadow[s1];
        vb = shadow[s2];
        sb_push(op, s1, s2, dl, dh);
        set_instr(op, s1, s2, dl, dh);
        in_valid = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
        check("issue_alu_en", alu_en, 1);
        check("issue_alu_op", alu_op, op);
        check("issue_a1", alu_a1, va);
        check("issue_a2", alu_a2, vb);
        check("issue_done", done, 0);
        tick();
        check("wb_alu_en", alu_en, 0);
        check("wb_done", done, 1);
        tick();
        check("idle_done", done, 0);
        check("idle_in_ready", in_ready, 1);
        sb_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t d_new, e_new, p_new;

        tv[0] = '{OP_ADD, 0, 1, 2, 3, splat(32'hFFFFFFFF), splat(32'h1), splat(32'h0), splat(32'h1)};
        tv[1] = '{OP_MUL, 4, 5, 6, 7, splat(32'h00010000), ramp(32'h00010000, 32'h1),
                  ramp(32'h0, 32'h00010000), splat(32'h1)};
        tv[2] = '{OP_ADD, 0, 1, 2, 2, splat(32'hFFFFFFFF), splat(32'h1), splat(32'h1), splat(32'h1)};
        tv[3] = '{OP_MUL, 3, 3, 4, 5, splat(32'hFFFFFFFF), splat(32'hFFFFFFFF),
                  splat(32'h1), splat(32'hFFFFFFFE)};
        tv[4] = '{OP_ADD, 6, 7, 6, 7, splat(32'h12345678), splat(32'h0EDCBA98),
                  splat(32'h21111110), splat(32'h0)};

        rst = 1'b1; in_valid = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        set_instr(1'b0, 0, 0, 0, 0);
        for (int i = 0; i < NREG; i++) shadow[i] = '0;

        // reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_alu_en", alu_en, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a1", alu_a1, '0);
        check("rst_alu_a2", alu_a2, '0);
        check("rst_done", done, 0);
        for (int i = 0; i < NREG; i++) rd_check("rst_rf", i, '0);

        // vector table
        for (int t = 0; t < 5; t++) begin
            load(tv[t].s1, tv[t].v1);
            load(tv[t].s2, tv[t].v2);
            issue(tv[t].op, tv[t].s1, tv[t].s2, tv[t].dl, tv[t].dh);
            rd_check("tv_lo", tv[t].dl, (tv[t].dl == tv[t].dh) ? tv[t].exp_hi : tv[t].exp_lo);
            rd_check("tv_hi", tv[t].dh, tv[t].exp_hi);
        end

        // host load in WB is stalled, the held request lands one cycle later
        load(0, splat(32'h00000010));
        load(1, splat(32'h00000020));
        p_new = splat(32'hCAFEF00D);
        sb_push(OP_ADD, 0, 1, 3, 4);
        set_instr(OP_ADD, 0, 1, 3, 4);
        in_valid = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
        tick();
        ld_en = 1'b1; ld_addr = AW'(5); ld_data = p_new;
        #1;
        check("wb_ld_ready", ld_ready, 0);
        check("wb_done_ld", done, 1);
        tick();
        check("post_wb_ld_ready", ld_ready, 1);
        rd_check("wb_ld_dropped", 5, shadow[5]);
        tick();
        ld_en = 1'b0;
        shadow[5] = p_new;
        rd_check("wb_ld_landed", 5, p_new);
        sb_drain();

        // load and accept in one IDLE cycle, then load a source during ISSUE
        load(1, splat(32'h00000003));
        d_new = ramp(32'h00000100, 32'h1);
        e_new = splat(32'hDEAD0000);
        shadow[0] = d_new;
        sb_push(OP_ADD, 0, 1, 2, 3);
        ld_en = 1'b1; ld_addr = AW'(0); ld_data = d_new;
        set_instr(OP_ADD, 0, 1, 2, 3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ld_addr = AW'(1); ld_data = e_new;
        check("same_cyc_a1_new", alu_a1, d_new);
        check("issue_ld_a2_old", alu_a2, splat(32'h00000003));
        tick();
        ld_en = 1'b0;
        shadow[1] = e_new;
        check("ovl_done", done, 1);
        tick();
        sb_drain();
        rd_check("ovl_r2_explicit", 2, ramp(32'h00000103, 32'h1));
        rd_check("issue_ld_r1", 1, e_new);

        // reset during WB: no writeback, no done, file cleared
        load(2, splat(32'h5A5A5A5A));
        set_instr(OP_ADD, 0, 1, 2, 2);
        in_valid = 1'b1;
        wait_ready();
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rst_wb_done", done, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) shadow[i] = '0;
        check("rst_wb_in_ready", in_ready, 1);
        check("rst_wb_alu_en", alu_en, 0);
        check("rst_wb_done_after", done, 0);
        rd_check("rst_wb_r2", 2, '0);
        rd_check("rst_wb_r0", 0, '0);
        tick();
        check("rst_wb_done_later", done, 0);

        // back-to-back with in_valid held; second reads the first's result
        load(0, splat(32'h00000005));
        load(1, splat(32'h00000007));
        sb_push(OP_ADD, 0, 1, 2, 3);
        sb_push(OP_MUL, 2, 2, 4, 5);
        set_instr(OP_ADD, 0, 1, 2, 3);
        in_valid = 1'b1;
        wait_ready();
        tick();
        set_instr(OP_MUL, 2, 2, 4, 5);
        check("b2b_a_issue", alu_en, 1);
        check("b2b_rdy_issue", in_ready, 0);
        tick();
        check("b2b_rdy_wb", in_ready, 0);
        check("b2b_a_done", done, 1);
        tick();
        check("b2b_rdy_idle", in_ready, 1);
        check("b2b_idle_alu_en", alu_en, 0);
        tick();
        in_valid = 1'b0;
        check("b2b_b_issue", alu_en, 1);
        check("b2b_b_op", alu_op, OP_MUL);
        check("b2b_b_a1", alu_a1, splat(32'h0000000C));
        tick();
        check("b2b_b_done", done, 1);
        tick();
        sb_drain();
        rd_check("b2b_r4", 4, splat(32'h00000090));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
